long_division_seq: RTL and testbench
====================================

Name: long_division_seq

Overview:
Parametrised iterative restoring long divider. It replaces the single-register pass-through stage in the longDivision area with a real multi-cycle quotient/remainder engine. It sits between an upstream producer and a downstream consumer, with valid/ready handshakes on both sides. It resolves one quotient bit per clock, supports signed or unsigned operands, and flags division by zero.

Parameters:
DATA_WIDTH, 8, width of dividend, divisor, quotient and remainder (min 2)
SIGNED_MODE, 0, 0 = unsigned operands; 1 = two's-complement operands, truncating division

Ports:
i_clk  input  1  clock, all logic on rising edge
i_reset_n  input  1  synchronous active-low reset
i_valid  input  1  operands valid
o_ready  output  1  block can accept operands (high only in IDLE)
i_dividend  input  DATA_WIDTH  dividend
i_divisor  input  DATA_WIDTH  divisor
o_valid  output  1  result valid, held until accepted
i_ready  input  1  downstream accepts result
o_quotient  output  DATA_WIDTH  quotient
o_remainder  output  DATA_WIDTH  remainder
o_div_by_zero  output  1  result came from a zero divisor

Behaviour:
- Reset (i_reset_n low at an edge): state goes to IDLE. o_valid, o_quotient, o_remainder and o_div_by_zero are cleared to 0. Iteration counter and working registers are cleared. o_ready reads 1 from the cycle after reset.
- States: IDLE, DIVIDE, DONE. o_ready = (state==IDLE), decoded combinationally from the state register.
- Accept: at an edge with i_valid && o_ready, the block latches the operands and moves IDLE->DIVIDE. If the divisor is 0, it moves IDLE->DONE instead. i_valid while not in IDLE is ignored.
- SIGNED_MODE=1:
  - Latch the magnitudes of both operands, computed modulo 2^DATA_WIDTH.
  - Record neg_q = sign(dividend) XOR sign(divisor) and neg_r = sign(dividend).
- DIVIDE iteration: DATA_WIDTH cycles, one per edge, MSB first.
  - rem = {rem[W-2:0], dvd[W-1]}; dvd <<= 1.
  - If rem >= divisor: rem -= divisor and the new quotient bit = 1; otherwise the quotient bit = 0.
  - Compare and subtract use W+1 bits so nothing is lost.
- DIVIDE->DONE occurs on the edge completing iteration DATA_WIDTH.
- Output registers are loaded on the DIVIDE->DONE edge. In SIGNED_MODE=1, the quotient is negated if neg_q and the remainder is negated if neg_r.
- Latency: o_valid rises DATA_WIDTH+1 edges after the accepting edge. For a zero divisor it rises 1 edge after.
- Divide by zero: o_quotient = all ones, o_remainder = dividend as presented, o_div_by_zero = 1. Signed mode applies no sign fix-up.
- Signed overflow (most-negative / -1): o_quotient = most-negative value (wraps), o_remainder = 0, no flag.
- DONE:
  - o_valid = 1; o_quotient, o_remainder and o_div_by_zero are held stable while i_ready = 0.
  - On an edge with i_ready = 1, the block moves DONE->IDLE and clears o_valid. o_quotient, o_remainder and o_div_by_zero keep their values until the next result is loaded.
  - Minimum initiation interval: DATA_WIDTH+2 cycles.
- Reset mid-operation (DIVIDE or DONE) aborts immediately. The block goes to IDLE with all outputs cleared, and no result is emitted.
- i_ready in IDLE or DIVIDE has no effect.

Test Plan:
- Unsigned, W=8: 100/7 accepted at edge k -> o_valid at edge k+9 with q=14 (0x0E), r=2; o_div_by_zero=0.
- Divide by zero: 55/0 -> o_valid at edge k+1, q=0xFF, r=0x37, o_div_by_zero=1; block returns to IDLE on i_ready.
- SIGNED_MODE=1, W=8:
  - -7/2 -> q=0xFD (-3), r=0xFF (-1).
  - 7/-2 -> q=0xFD, r=0x01.
  - -128/-1 -> q=0x80, r=0x00, no flag.
- Backpressure: hold i_ready=0 for 5 cycles in DONE -> o_valid, q, r stable all 5 cycles. o_ready stays 0 and a new i_valid is ignored. Release -> o_ready=1 the next cycle.
- Reset at iteration 4 of 255/3 -> o_valid never asserts and outputs read 0. A following 255/3 -> q=85, r=0 with normal latency.
- Sweep: random operand pairs at W=8 and W=16 in both modes against a reference model, with random i_valid/i_ready gaps; zero divisors are checked separately.

Source files
------------

// File: rtl/long_division_seq.sv
// -----------------------------------------------------------------------------
// long_division_seq
//   Iterative restoring long divider that resolves one quotient bit per clock,
//   MSB first. Operands may be unsigned or two's complement (truncating
//   division, remainder takes the sign of the dividend). A zero divisor
//   bypasses the iteration and returns quotient = all ones,
//   remainder = dividend, with o_div_by_zero set.
//
// Ports
//   i_clk         clock, all logic on the rising edge
//   i_reset_n     synchronous active-low reset
//   i_valid       operands valid (accepted only while o_ready is high)
//   o_ready       high only while idle
//   i_dividend    dividend, DATA_WIDTH bits
//   i_divisor     divisor, DATA_WIDTH bits
//   o_valid       result valid, held until i_ready
//   i_ready       downstream accepts the result
//   o_quotient    quotient, DATA_WIDTH bits
//   o_remainder   remainder, DATA_WIDTH bits
//   o_div_by_zero result came from a zero divisor
// -----------------------------------------------------------------------------
module long_division_seq #(
    parameter int DATA_WIDTH  = 8,
    parameter int SIGNED_MODE = 0
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [DATA_WIDTH-1:0] i_dividend,
    input  logic [DATA_WIDTH-1:0] i_divisor,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_quotient,
    output logic [DATA_WIDTH-1:0] o_remainder,
    output logic                  o_div_by_zero
);

    localparam int W   = DATA_WIDTH;
    localparam int CW  = $clog2(W);
    localparam bit SGN = (SIGNED_MODE != 0);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_DIVIDE = 2'b01,
        ST_DONE   = 2'b10
    } state_t;

    // Two's-complement negation modulo 2^W.
    function automatic logic [W-1:0] neg_f(input logic [W-1:0] v);
        return ~v + {{(W-1){1'b0}}, 1'b1};
    endfunction

    // Magnitude modulo 2^W; the most-negative value maps onto itself, which
    // reads correctly as an unsigned magnitude.
    function automatic logic [W-1:0] mag_f(input logic [W-1:0] v);
        if (SGN && v[W-1]) begin
            return neg_f(v);
        end else begin
            return v;
        end
    endfunction

    state_t          state_r;
    state_t          state_nxt_s;
    logic [CW-1:0]   cnt_r;
    logic [W-1:0]    rem_r;
    logic [W-1:0]    dvd_r;      // dividend shifts out MSB-first, quotient bits shift in
    logic [W-1:0]    dvs_r;
    logic            quo_neg_r;
    logic            rem_neg_r;
    logic            valid_r;
    logic [W-1:0]    quo_out_r;
    logic [W-1:0]    rem_out_r;
    logic            dbz_r;

    logic [W:0]      rem_shift_s;
    logic [W:0]      diff_s;
    logic            ge_s;
    logic [W-1:0]    rem_nxt_s;
    logic [W-1:0]    quo_nxt_s;
    logic [W-1:0]    quo_fix_s;
    logic [W-1:0]    rem_fix_s;
    logic            last_iter_s;
    logic            div_zero_s;

    assign last_iter_s = (cnt_r == CW'(W-1));
    assign div_zero_s  = (i_divisor == {W{1'b0}});

    // One restoring step. The partial remainder is always below the divisor,
    // so after the shift a non-negative difference fits in W bits and a
    // negative one shows up as bit W of the W+1-bit subtraction.
    always_comb begin
        rem_shift_s = {rem_r, dvd_r[W-1]};
        diff_s      = rem_shift_s - {1'b0, dvs_r};
        ge_s        = ~diff_s[W];
        if (ge_s) begin
            rem_nxt_s = diff_s[W-1:0];
        end else begin
            rem_nxt_s = rem_shift_s[W-1:0];
        end
        quo_nxt_s = {dvd_r[W-2:0], ge_s};
    end

    // Sign fix-up applied to the final step's results.
    always_comb begin
        if (quo_neg_r) begin
            quo_fix_s = neg_f(quo_nxt_s);
        end else begin
            quo_fix_s = quo_nxt_s;
        end
        if (rem_neg_r) begin
            rem_fix_s = neg_f(rem_nxt_s);
        end else begin
            rem_fix_s = rem_nxt_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (i_valid) begin
                    if (div_zero_s) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_DIVIDE;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_DIVIDE: begin
                if (last_iter_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_DIVIDE;
                end
            end
            ST_DONE: begin
                if (i_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Operand capture, iteration datapath and result registers.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            cnt_r     <= {CW{1'b0}};
            rem_r     <= {W{1'b0}};
            dvd_r     <= {W{1'b0}};
            dvs_r     <= {W{1'b0}};
            quo_neg_r <= 1'b0;
            rem_neg_r <= 1'b0;
            valid_r   <= 1'b0;
            quo_out_r <= {W{1'b0}};
            rem_out_r <= {W{1'b0}};
            dbz_r     <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (i_valid) begin
                        cnt_r     <= {CW{1'b0}};
                        rem_r     <= {W{1'b0}};
                        dvd_r     <= mag_f(i_dividend);
                        dvs_r     <= mag_f(i_divisor);
                        quo_neg_r <= SGN & (i_dividend[W-1] ^ i_divisor[W-1]);
                        rem_neg_r <= SGN & i_dividend[W-1];
                        if (div_zero_s) begin
                            // No sign fix-up: the raw dividend is returned.
                            quo_out_r <= {W{1'b1}};
                            rem_out_r <= i_dividend;
                            dbz_r     <= 1'b1;
                            valid_r   <= 1'b1;
                        end
                    end
                end
                ST_DIVIDE: begin
                    rem_r <= rem_nxt_s;
                    dvd_r <= quo_nxt_s;
                    cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
                    if (last_iter_s) begin
                        quo_out_r <= quo_fix_s;
                        rem_out_r <= rem_fix_s;
                        dbz_r     <= 1'b0;
                        valid_r   <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (i_ready) begin
                        valid_r <= 1'b0;
                    end
                end
                default: begin
                    valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign o_ready       = (state_r == ST_IDLE);
    assign o_valid       = valid_r;
    assign o_quotient    = quo_out_r;
    assign o_remainder   = rem_out_r;
    assign o_div_by_zero = dbz_r;

endmodule

// File: tb/tb_long_division_seq.sv
// -----------------------------------------------------------------------------
// tb_long_division_seq
//   Four divider instances (8-bit unsigned, 8-bit signed, 16-bit unsigned,
//   16-bit signed) share a clock, reset and operand bus; one is exercised at a
//   time. Expected results come from plain integer division on sign-extended
//   operands, masked back to the instance width.
// -----------------------------------------------------------------------------
module tb_long_division_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  vin;
    logic        iready;
    logic [15:0] dvd;
    logic [15:0] dvs;

    logic [3:0]  rdy;
    logic [3:0]  vout;
    logic [3:0]  dbz;
    logic [7:0]  q_a, r_a, q_b, r_b;
    logic [15:0] q_c, r_c, q_d, r_d;

    int          sel;
    logic        rdy_obs, vout_obs, dbz_obs;
    logic [15:0] q_obs, r_obs;

    int err_cnt = 0;
    int chk_cnt = 0;

    always #5 clk = ~clk;

    long_division_seq #(.DATA_WIDTH(8), .SIGNED_MODE(0)) u_8u (
        .i_clk(clk), .i_reset_n(rst_n), .i_valid(vin[0]), .o_ready(rdy[0]),
        .i_dividend(dvd[7:0]), .i_divisor(dvs[7:0]), .o_valid(vout[0]),
        .i_ready(iready), .o_quotient(q_a), .o_remainder(r_a), .o_div_by_zero(dbz[0]));

    long_division_seq #(.DATA_WIDTH(8), .SIGNED_MODE(1)) u_8s (
        .i_clk(clk), .i_reset_n(rst_n), .i_valid(vin[1]), .o_ready(rdy[1]),
        .i_dividend(dvd[7:0]), .i_divisor(dvs[7:0]), .o_valid(vout[1]),
        .i_ready(iready), .o_quotient(q_b), .o_remainder(r_b), .o_div_by_zero(dbz[1]));

    long_division_seq #(.DATA_WIDTH(16), .SIGNED_MODE(0)) u_16u (
        .i_clk(clk), .i_reset_n(rst_n), .i_valid(vin[2]), .o_ready(rdy[2]),
        .i_dividend(dvd), .i_divisor(dvs), .o_valid(vout[2]),
        .i_ready(iready), .o_quotient(q_c), .o_remainder(r_c), .o_div_by_zero(dbz[2]));

    long_division_seq #(.DATA_WIDTH(16), .SIGNED_MODE(1)) u_16s (
        .i_clk(clk), .i_reset_n(rst_n), .i_valid(vin[3]), .o_ready(rdy[3]),
        .i_dividend(dvd), .i_divisor(dvs), .o_valid(vout[3]),
        .i_ready(iready), .o_quotient(q_d), .o_remainder(r_d), .o_div_by_zero(dbz[3]));

    // Observe the selected instance.
    always_comb begin
        rdy_obs  = rdy[sel[1:0]];
        vout_obs = vout[sel[1:0]];
        dbz_obs  = dbz[sel[1:0]];
        case (sel)
            0:       begin q_obs = {8'h00, q_a}; r_obs = {8'h00, r_a}; end
            1:       begin q_obs = {8'h00, q_b}; r_obs = {8'h00, r_b}; end
            2:       begin q_obs = q_c;          r_obs = r_c;          end
            default: begin q_obs = q_d;          r_obs = r_d;          end
        endcase
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s (inst %0d): got=%0h expected=%0h", tag, sel, got, exp);
        end
    endtask

    function automatic int wid_of(input int s);
        return (s < 2) ? 8 : 16;
    endfunction

    function automatic bit sgn_of(input int s);
        return (s == 1) || (s == 3);
    endfunction

    // Reference: truncating integer division on the operands' numeric values.
    function automatic void ref_div(input int w, input bit sgn, input logic [15:0] a,
                                    input logic [15:0] b, output logic [15:0] q,
                                    output logic [15:0] r, output bit z);
        longint mask, av, bv;
        mask = (longint'(1) << w) - 1;
        av   = longint'(a) & mask;
        bv   = longint'(b) & mask;
        if (sgn && av[w-1]) av = av - (longint'(1) << w);
        if (sgn && bv[w-1]) bv = bv - (longint'(1) << w);
        if (bv == 0) begin
            q = 16'(mask);
            r = 16'(longint'(a) & mask);
            z = 1'b1;
        end else begin
            q = 16'((av / bv) & mask);
            r = 16'((av % bv) & mask);
            z = 1'b0;
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction on instance s, with `stall` cycles of backpressure
    // (optionally presenting ignored operands meanwhile).
    task automatic run_op(input int s, input logic [15:0] a, input logic [15:0] b,
                          input int stall, input bit poke);
        logic [15:0] eq, er;
        bit          ez;
        int          lat;
        sel = s;
        #1;
        ref_div(wid_of(s), sgn_of(s), a, b, eq, er, ez);
        check_eq("ready_idle", 32'(rdy_obs), 32'd1);
        vin[s] = 1'b1;
        dvd    = a;
        dvs    = b;
        tick();                          // accepting edge
        vin[s] = 1'b0;
        dvd    = 16'($urandom);
        dvs    = 16'($urandom);
        // o_valid is set by edge k+W (seen at edge k+W+1), or by the
        // accepting edge itself for a zero divisor.
        lat = 0;
        while (!vout_obs && lat < 40) begin
            tick();
            lat++;
        end
        check_eq("latency", 32'(lat), ez ? 32'd0 : 32'(wid_of(s)));
        check_eq("ready_busy", 32'(rdy_obs), 32'd0);
        check_eq("quotient", 32'(q_obs), 32'(eq));
        check_eq("remainder", 32'(r_obs), 32'(er));
        check_eq("div_by_zero", 32'(dbz_obs), 32'(ez));
        for (int i = 0; i < stall; i++) begin
            if (poke) begin
                vin[s] = 1'b1;
                dvd    = 16'($urandom);
                dvs    = 16'($urandom);
            end
            tick();
            check_eq("hold_valid", 32'(vout_obs), 32'd1);
            check_eq("hold_ready", 32'(rdy_obs), 32'd0);
            check_eq("hold_q", 32'(q_obs), 32'(eq));
            check_eq("hold_r", 32'(r_obs), 32'(er));
        end
        vin[s] = 1'b0;
        iready = 1'b1;
        tick();
        iready = 1'b0;
        check_eq("release_valid", 32'(vout_obs), 32'd0);
        check_eq("release_ready", 32'(rdy_obs), 32'd1);
        check_eq("keep_q", 32'(q_obs), 32'(eq));
        check_eq("keep_r", 32'(r_obs), 32'(er));
        check_eq("keep_dbz", 32'(dbz_obs), 32'(ez));
    endtask

    initial begin
        int seen;
        logic [15:0] a, b;
        sel    = 0;
        rst_n  = 1'b0;
        vin    = 4'b0000;
        iready = 1'b0;
        dvd    = 16'h0000;
        dvs    = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset state of every instance.
        for (int s = 0; s < 4; s++) begin
            sel = s;
            #1;
            check_eq("rst_ready", 32'(rdy_obs), 32'd1);
            check_eq("rst_valid", 32'(vout_obs), 32'd0);
            check_eq("rst_q", 32'(q_obs), 32'd0);
            check_eq("rst_r", 32'(r_obs), 32'd0);
            check_eq("rst_dbz", 32'(dbz_obs), 32'd0);
        end

        // Directed cases.
        run_op(0, 16'd100, 16'd7, 0, 1'b0);        // q=14 r=2
        run_op(0, 16'd55, 16'd0, 1, 1'b0);         // q=FF r=37 flag
        run_op(1, 16'h00F9, 16'h0002, 0, 1'b0);    // -7/2  -> FD, FF
        run_op(1, 16'h0007, 16'h00FE, 0, 1'b0);    // 7/-2  -> FD, 01
        run_op(1, 16'h0080, 16'h00FF, 0, 1'b0);    // -128/-1 -> 80, 00
        run_op(3, 16'h8000, 16'hFFFF, 0, 1'b0);    // 16-bit overflow
        run_op(1, 16'h0085, 16'h0000, 0, 1'b0);    // signed dbz, raw dividend back
        run_op(0, 16'd200, 16'd9, 5, 1'b1);        // backpressure with ignored i_valid
        run_op(0, 16'hFF, 16'hFF, 0, 1'b0);
        run_op(0, 16'd3, 16'd200, 0, 1'b0);

        // Reset during iteration 4 of 255/3.
        sel = 0;
        vin[0] = 1'b1;
        dvd    = 16'd255;
        dvs    = 16'd3;
        tick();
        vin[0] = 1'b0;
        repeat (4) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_eq("abort_ready", 32'(rdy_obs), 32'd1);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (vout_obs) seen = 1;
        end
        check_eq("abort_no_valid", 32'(seen), 32'd0);
        check_eq("abort_q", 32'(q_obs), 32'd0);
        check_eq("abort_r", 32'(r_obs), 32'd0);
        run_op(0, 16'd255, 16'd3, 0, 1'b0);        // q=85 r=0

        // Random sweep, non-zero divisors.
        for (int s = 0; s < 4; s++) begin
            for (int n = 0; n < 40; n++) begin
                a = 16'($urandom);
                b = 16'($urandom);
                if (wid_of(s) == 8) b[15:8] = 8'h00;
                if (b == 16'h0000) b = 16'h0001;
                repeat ($urandom_range(0, 3)) tick();
                run_op(s, a, b, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            end
        end

        // Zero divisors on every instance.
        for (int s = 0; s < 4; s++) begin
            run_op(s, 16'($urandom), 16'h0000, 1, 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
